id_stage_sb: RTL
================

Name: id_stage_sb

Overview:
Registered MIPS decode stage with a valid/ready handshake on both sides. It decodes one instruction per cycle and forwards operands from NUM_FWD parametrised bypass sources. A load scoreboard with configurable load latency detects load-use hazards and inserts bubbles. BEQ/BNE resolve in ID, and the stage tracks the delay slot itself. Sits between the IF/ID register and EX, and drives the register-file read ports combinationally.

Parameters:
DATA_W, 32, datapath width
NUM_FWD, 2, number of bypass sources; index 0 is youngest (highest priority)
LOAD_LAT, 1, cycles after a load leaves ID during which its result is not forwardable (1..4)
ALU_OP_W, 8, aluop encoding width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush_i  in  1  kill the held output and the delay-slot flag
in_valid  in  1  instruction valid from IF
in_ready  out  1  ID accepts the instruction this cycle
pc_i  in  DATA_W  instruction PC
inst_i  in  32  instruction word
rf_re1_o, rf_re2_o  out  1  register-file read enables
rf_ra1_o, rf_ra2_o  out  5  read addresses (rs, rt)
rf_rd1_i, rf_rd2_i  in  DATA_W  read data
fwd_en_i  in  NUM_FWD  bypass write enables
fwd_addr_i  in  5*NUM_FWD  bypass destination registers
fwd_data_i  in  DATA_W*NUM_FWD  bypass data
out_valid  out  1  ID/EX register holds a valid op
out_ready  in  1  EX accepts the op
aluop_o  out  ALU_OP_W  ALU operation
op1_o, op2_o  out  DATA_W  operands
store_data_o  out  DATA_W  rt value for SW
wr_en_o  out  1  write-back enable
wr_addr_o  out  5  write-back register
is_delayslot_o  out  1  op is a branch delay slot
branch_flag_o  out  1  taken branch, combinational, valid in the fire cycle
branch_addr_o  out  DATA_W  branch target

Behaviour:
- Decoded set:
  - R-type with sa=0: ADDU, SUBU, AND, OR, XOR, NOR.
  - I-type: ORI, ANDI, XORI (zero-extended imm), ADDIU (sign-extended imm), LUI (op1=0, op2={imm,16'h0}).
  - BEQ, BNE.
  - LW: op1=rs, op2=sext(imm), wr rt.
  - SW: op1=rs, op2=sext(imm), store_data_o=rt, no write.
  - Anything else decodes as NOP: aluop=NOP, no reads, no write.
- Operand select per read port:
  - Port disabled gives 0, or the immediate for op2.
  - Otherwise take the lowest-index bypass i with fwd_en_i[i] and matching address; if none matches, take rf data.
  - Register $0 is never forwarded and always yields 0.
- Scoreboard: shift chain of LOAD_LAT entries {valid, addr}.
  - On an LW fire with rt≠0, an entry enters at the head.
  - The chain advances on any cycle where out_ready=1 or out_valid=0.
  - hazard = in_valid & an enabled read port matches a valid entry (addr≠0).
- Handshake:
  - in_ready = !hazard & (!out_valid | out_ready).
  - fire = in_valid & in_ready.
  - On fire, the output register loads the decoded fields and out_valid=1.
  - On a hazard with downstream free, a bubble is loaded (out_valid=0, wr_en_o=0).
  - If out_valid & !out_ready, all outputs hold.
- Branches:
  - branch_flag_o = fire & BEQ/BNE condition met on the forwarded operands.
  - Target = pc_i + 4 + (sext(imm) << 2). branch_addr_o = 0 when not taken.
- Delay slot:
  - Internal ds_flag is set on the fire of any BEQ/BNE, taken or not.
  - The next fired instruction captures is_delayslot_o = ds_flag, and ds_flag then clears.
- flush_i:
  - Clears out_valid and ds_flag next cycle.
  - The scoreboard is kept.
  - A simultaneous fire is discarded, and branch_flag_o is forced to 0.
- Reset: all registered outputs 0, out_valid=0, ds_flag=0, scoreboard cleared. Reset asserted mid-stall drops the held op.
- Latency: 1 cycle from fire to out_valid.

Optional Feature:
ID_EXC_EN:
- When defined, adds output exc_ri_o (1 bit), registered with the op.
- An undecodable instruction sets exc_ri_o=1 with out_valid=1 and aluop=NOP.
- When undefined, there is no port and undecodable instructions become plain NOPs with out_valid=1.

Decomposition:
- Package id_pkg holds: opcode and funct constants, ALU_OP encodings (NOP, ADD, SUB, AND, OR, XOR, NOR, LW, SW), ALU_OP_W, and the idex_t struct of output fields.
- Sub-module id_load_sb (scoreboard chain plus hazard compare), parametrised by LOAD_LAT.

Test Plan:
1. ORI $1,$0,0x00FF then ADDU $2,$1,$1 with fwd[0]={1,1,0xFF} → op1=op2=0xFF, no stall.
2. LW $3,0($0), then ADDU $4,$3,$0 with LOAD_LAT=1 → in_ready=0 for 1 cycle, one bubble, then fire.
3. BNE $1,$2 with rf=5,6, pc=0x100, imm=0x0003 → branch_flag_o=1, addr=0x110; next op has is_delayslot_o=1.
4. out_ready=0 for 3 cycles with out_valid=1 → outputs stable; in_ready=0; scoreboard frozen.
5. flush_i in the same cycle as BEQ fire → out_valid=0 next cycle, branch_flag_o=0, following op has is_delayslot_o=0.
6. inst_i=0xFC000000 → with ID_EXC_EN, exc_ri_o=1 and aluop=NOP; without it, a plain NOP.

Source files
------------

// File: rtl/id_stage_sb_pkg.sv
// Decode constants, ALU operation encodings and the ID/EX control record.
// Optional macro ID_EXC_EN adds the reserved-instruction flag to the record.
package id_pkg;

    localparam int ALU_OP_W = 8;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    localparam logic [ALU_OP_W-1:0] ALU_NOP = 8'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 8'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 8'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 8'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 8'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 8'd5;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 8'd6;
    localparam logic [ALU_OP_W-1:0] ALU_LW  = 8'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SW  = 8'd8;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_SEXT = 2'd2,
        IMM_LUI  = 2'd3
    } imm_sel_e;

    typedef struct packed {
        logic [ALU_OP_W-1:0] aluop;
        logic                wr_en;
        logic [4:0]          wr_addr;
        logic                is_delayslot;
`ifdef ID_EXC_EN
        logic                exc_ri;
`endif
    } idex_t;

endpackage

// File: rtl/id_stage_sb_if.sv
// Upstream (IF/ID) and downstream (ID/EX) handshake bundle of the decode stage.
// master = the decode stage, slave = its environment.
interface id_stage_sb_if #(
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   pc_i;
    logic [31:0]         inst_i;
    logic                out_valid;
    logic                out_ready;
    logic [ALU_OP_W-1:0] aluop_o;
    logic [DATA_W-1:0]   op1_o;
    logic [DATA_W-1:0]   op2_o;
    logic [DATA_W-1:0]   store_data_o;
    logic                wr_en_o;
    logic [4:0]          wr_addr_o;
    logic                is_delayslot_o;

    modport master (
        input  in_valid, pc_i, inst_i, out_ready,
        output in_ready, out_valid, aluop_o, op1_o, op2_o, store_data_o,
               wr_en_o, wr_addr_o, is_delayslot_o
    );

    modport slave (
        output in_valid, pc_i, inst_i, out_ready,
        input  in_ready, out_valid, aluop_o, op1_o, op2_o, store_data_o,
               wr_en_o, wr_addr_o, is_delayslot_o
    );
endinterface

// File: rtl/id_stage_sb_load_sb.sv
// Load scoreboard: a LOAD_LAT-deep chain of in-flight load destinations and
// the load-use hazard compare against the current read ports.
module id_load_sb #(
    parameter int LOAD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance_i,
    input  logic       push_i,
    input  logic [4:0] push_addr_i,
    input  logic       in_valid_i,
    input  logic       re1_i,
    input  logic [4:0] ra1_i,
    input  logic       re2_i,
    input  logic [4:0] ra2_i,
    output logic       hazard_o
);
    logic [LOAD_LAT-1:0] vld_q, vld_d;
    logic [4:0]          addr_q [LOAD_LAT];
    logic [4:0]          addr_d [LOAD_LAT];
    logic                hit_s;

    // Shift the chain only while the ID/EX register is moving.
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (advance_i) begin
            vld_d[0]  = push_i;
            addr_d[0] = push_addr_i;
            for (int i = 1; i < LOAD_LAT; i++) begin
                vld_d[i]  = vld_q[i-1];
                addr_d[i] = addr_q[i-1];
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Any enabled read port naming a pending load destination is a hazard.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (vld_q[i] && (addr_q[i] != 5'd0) &&
                ((re1_i && (ra1_i == addr_q[i])) || (re2_i && (ra2_i == addr_q[i])))) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign hazard_o = in_valid_i & hit_s;

    // Chain register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= {LOAD_LAT{1'b0}};
            for (int i = 0; i < LOAD_LAT; i++) addr_q[i] <= 5'd0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/id_stage_sb.sv
// Registered MIPS decode stage with operand bypass, load-use stall and
// in-ID branch resolution. Optional macro ID_EXC_EN adds exc_ri_o.
module id_stage_sb
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    id_stage_sb_if.master          bus,
    output logic                   rf_re1_o,
    output logic                   rf_re2_o,
    output logic [4:0]             rf_ra1_o,
    output logic [4:0]             rf_ra2_o,
    input  logic [DATA_W-1:0]      rf_rd1_i,
    input  logic [DATA_W-1:0]      rf_rd2_i,
    input  logic [NUM_FWD-1:0]     fwd_en_i,
    input  logic [5*NUM_FWD-1:0]   fwd_addr_i,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_data_i,
`ifdef ID_EXC_EN
    output logic                   exc_ri_o,
`endif
    output logic                   branch_flag_o,
    output logic [DATA_W-1:0]      branch_addr_o
);
    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, sa_s;
    logic [15:0] imm_s;
    logic        re1_s, re2_s, is_br_s, is_lw_s, is_sw_s, known_s;
    imm_sel_e    imm_sel_s;
    idex_t       dec_s, idex_q, idex_d;
    logic [DATA_W-1:0] imm_val_s, val1_s, val2_s, sext_s;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, store_q, store_d;
    logic        out_valid_q, out_valid_d, ds_q, ds_d;
    logic        hazard_s, down_free_s, fire_s, accept_s, taken_s;

    assign opcode_s = bus.inst_i[31:26];
    assign rs_s     = bus.inst_i[25:21];
    assign rt_s     = bus.inst_i[20:16];
    assign rd_s     = bus.inst_i[15:11];
    assign sa_s     = bus.inst_i[10:6];
    assign funct_s  = bus.inst_i[5:0];
    assign imm_s    = bus.inst_i[15:0];

    // Lowest-index matching bypass wins; $0 always reads as zero.
    function automatic logic [DATA_W-1:0] fwd_sel(input logic [4:0] ra,
                                                  input logic [DATA_W-1:0] rf);
        logic [DATA_W-1:0] v;
        v = rf;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_en_i[i] && (fwd_addr_i[5*i +: 5] == ra)) v = fwd_data_i[DATA_W*i +: DATA_W];
            else v = v;
        end
        return (ra == 5'd0) ? {DATA_W{1'b0}} : v;
    endfunction

    // Instruction decode into control fields, read enables and immediate kind.
    always_comb begin
        dec_s     = '0;
        dec_s.aluop = ALU_NOP;
        re1_s     = 1'b0;
        re2_s     = 1'b0;
        is_br_s   = 1'b0;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        known_s   = 1'b1;
        imm_sel_s = IMM_NONE;
        case (opcode_s)
            OP_SPECIAL: begin
                case (funct_s)
                    FN_ADDU: dec_s.aluop = ALU_ADD;
                    FN_SUBU: dec_s.aluop = ALU_SUB;
                    FN_AND:  dec_s.aluop = ALU_AND;
                    FN_OR:   dec_s.aluop = ALU_OR;
                    FN_XOR:  dec_s.aluop = ALU_XOR;
                    FN_NOR:  dec_s.aluop = ALU_NOR;
                    default: dec_s.aluop = ALU_NOP;
                endcase
                if ((sa_s == 5'd0) && (dec_s.aluop != ALU_NOP)) begin
                    re1_s = 1'b1; re2_s = 1'b1;
                    dec_s.wr_en = 1'b1; dec_s.wr_addr = rd_s;
                end else begin
                    dec_s.aluop = ALU_NOP;
                    known_s = 1'b0;
                end
            end
            OP_ORI:   begin dec_s.aluop = ALU_OR;  re1_s = 1'b1; imm_sel_s = IMM_ZEXT; dec_s.wr_en = 1'b1; dec_s.wr_addr = rt_s; end
            OP_ANDI:  begin dec_s.aluop = ALU_AND; re1_s = 1'b1; imm_sel_s = IMM_ZEXT; dec_s.wr_en = 1'b1; dec_s.wr_addr = rt_s; end
            OP_XORI:  begin dec_s.aluop = ALU_XOR; re1_s = 1'b1; imm_sel_s = IMM_ZEXT; dec_s.wr_en = 1'b1; dec_s.wr_addr = rt_s; end
            OP_ADDIU: begin dec_s.aluop = ALU_ADD; re1_s = 1'b1; imm_sel_s = IMM_SEXT; dec_s.wr_en = 1'b1; dec_s.wr_addr = rt_s; end
            OP_LUI:   begin dec_s.aluop = ALU_OR;  imm_sel_s = IMM_LUI; dec_s.wr_en = 1'b1; dec_s.wr_addr = rt_s; end
            OP_BEQ, OP_BNE: begin re1_s = 1'b1; re2_s = 1'b1; is_br_s = 1'b1; end
            OP_LW:    begin dec_s.aluop = ALU_LW; re1_s = 1'b1; imm_sel_s = IMM_SEXT; is_lw_s = 1'b1; dec_s.wr_en = 1'b1; dec_s.wr_addr = rt_s; end
            OP_SW:    begin dec_s.aluop = ALU_SW; re1_s = 1'b1; re2_s = 1'b1; imm_sel_s = IMM_SEXT; is_sw_s = 1'b1; end
            default:  known_s = 1'b0;
        endcase
        dec_s.is_delayslot = ds_q;
`ifdef ID_EXC_EN
        dec_s.exc_ri = ~known_s;
`endif
    end

`ifndef ID_EXC_EN
    logic unused_known_s;
    assign unused_known_s = known_s;
`endif

    assign sext_s = {{(DATA_W-16){imm_s[15]}}, imm_s};

    // Immediate formatting and operand/bypass selection.
    always_comb begin
        case (imm_sel_s)
            IMM_ZEXT: imm_val_s = {{(DATA_W-16){1'b0}}, imm_s};
            IMM_SEXT: imm_val_s = sext_s;
            IMM_LUI:  imm_val_s = DATA_W'({imm_s, 16'h0000});
            default:  imm_val_s = {DATA_W{1'b0}};
        endcase
        val1_s = re1_s ? fwd_sel(rs_s, rf_rd1_i) : {DATA_W{1'b0}};
        val2_s = re2_s ? fwd_sel(rt_s, rf_rd2_i) : {DATA_W{1'b0}};
    end

    assign rf_re1_o = re1_s;
    assign rf_re2_o = re2_s;
    assign rf_ra1_o = rs_s;
    assign rf_ra2_o = rt_s;

    id_load_sb #(.LOAD_LAT(LOAD_LAT)) u_load_sb (
        .clk         (clk),
        .rst         (rst),
        .advance_i   (down_free_s),
        .push_i      (accept_s & is_lw_s & (rt_s != 5'd0)),
        .push_addr_i (rt_s),
        .in_valid_i  (bus.in_valid),
        .re1_i       (re1_s),
        .ra1_i       (rs_s),
        .re2_i       (re2_s),
        .ra2_i       (rt_s),
        .hazard_o    (hazard_s)
    );

    assign down_free_s  = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = ~hazard_s & down_free_s;
    assign fire_s       = bus.in_valid & bus.in_ready;
    // A fire coinciding with flush is consumed upstream but dropped here.
    assign accept_s     = fire_s & ~flush_i;

    assign taken_s       = accept_s & is_br_s &
                           ((opcode_s == OP_BEQ) ? (val1_s == val2_s) : (val1_s != val2_s));
    assign branch_flag_o = taken_s;
    assign branch_addr_o = taken_s ? (bus.pc_i + DATA_W'(32'd4) + {sext_s[DATA_W-3:0], 2'b00})
                                   : {DATA_W{1'b0}};

    // ID/EX register next state: flush, load, bubble or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        idex_d      = idex_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        store_d     = store_q;
        ds_d        = ds_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            idex_d.wr_en = 1'b0;
            ds_d         = 1'b0;
        end else if (fire_s) begin
            out_valid_d = 1'b1;
            idex_d      = dec_s;
            op1_d       = val1_s;
            op2_d       = (imm_sel_s != IMM_NONE) ? imm_val_s : val2_s;
            store_d     = is_sw_s ? val2_s : {DATA_W{1'b0}};
            ds_d        = is_br_s;
        end else if (down_free_s) begin
            out_valid_d  = 1'b0;
            idex_d.wr_en = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idex_q      <= '0;
            op1_q       <= {DATA_W{1'b0}};
            op2_q       <= {DATA_W{1'b0}};
            store_q     <= {DATA_W{1'b0}};
            ds_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            idex_q      <= idex_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            store_q     <= store_d;
            ds_q        <= ds_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.aluop_o        = idex_q.aluop;
    assign bus.op1_o          = op1_q;
    assign bus.op2_o          = op2_q;
    assign bus.store_data_o   = store_q;
    assign bus.wr_en_o        = idex_q.wr_en;
    assign bus.wr_addr_o      = idex_q.wr_addr;
    assign bus.is_delayslot_o = idex_q.is_delayslot;
`ifdef ID_EXC_EN
    assign exc_ri_o           = idex_q.exc_ri;
`endif
endmodule
